// File: rtl/cc_speedtick_pkg.sv
// cc_speedtick_pkg: shared defaults, level type and the effective-period rule
// for the speed-tick generator.
package cc_speedtick_pkg;
   localparam int DEF_LEVEL_WIDTH = 3;
   localparam int DEF_MAX_LEVEL   = 5;
   typedef logic [DEF_LEVEL_WIDTH-1:0] level_t;
   // Zero period means disabled; a non-zero period never shifts down to zero.
   function automatic logic [31:0] eff_period(input logic [31:0] period, input logic [31:0] level);
      logic [31:0] eff;
      eff = period >> level;
      return (period != '0 && eff == '0) ? 32'd1 : eff;
   endfunction
endpackage

// File: rtl/cc_speedtick_lane.sv
// cc_speedtick_lane: one free-running channel counter with a >= wrap compare
// and a registered active-low tick.
module cc_speedtick_lane
   import cc_speedtick_pkg::*;
#(
   parameter int DATAWIDTH   = 23,
   parameter int LEVEL_WIDTH = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [DATAWIDTH-1:0]   period,
   input  logic [LEVEL_WIDTH-1:0] level,
   input  logic                   run,
   output logic                   tick_n
);
   logic [DATAWIDTH-1:0] cnt_q, cnt_d;
   logic                 tick_q, tick_d;
   logic [31:0]          eff;
   logic                 off, wrap;
   always_comb begin
      eff    = eff_period(32'(period), 32'(level));
      off    = eff == '0;
      wrap   = 32'(cnt_q) >= eff - 32'd1;
      cnt_d  = off ? '0 : !run ? cnt_q : wrap ? '0 : cnt_q + DATAWIDTH'(1);
      tick_d = off || !run || !wrap;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q  <= '0;
         tick_q <= 1'b1;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= tick_d;
      end
   end
   assign tick_n = tick_q;
endmodule

// File: rtl/cc_speedtick_gen.sv
// cc_speedtick_gen: multi-channel speed-tick generator with a shared difficulty
// level; define CC_SPEEDTICK_PAUSE_EN to add the pause_InLow freeze input.
module cc_speedtick_gen
   import cc_speedtick_pkg::*;
#(
   parameter int DATAWIDTH    = 23,
   parameter int NUM_CHANNELS = 4,
   parameter int LEVEL_WIDTH  = DEF_LEVEL_WIDTH,
   parameter int MAX_LEVEL    = DEF_MAX_LEVEL
) (
   input  logic                           CLOCK_50,
   input  logic                           RESET_InHigh,
   input  logic [NUM_CHANNELS*DATAWIDTH-1:0] period_InBUS,
   input  logic                           level_up_In,
   input  logic                           level_clear_In,
`ifdef CC_SPEEDTICK_PAUSE_EN
   input  logic                           pause_InLow,
`endif
   output logic [NUM_CHANNELS-1:0]        tick_OutLow,
   output logic [LEVEL_WIDTH-1:0]         level_OutBUS
);
   logic [LEVEL_WIDTH-1:0] level_q, level_d;
   logic                   run;
`ifdef CC_SPEEDTICK_PAUSE_EN
   assign run = pause_InLow;
`else
   assign run = 1'b1;
`endif
   always_comb begin
      level_d = level_clear_In ? '0 :
                (level_up_In && level_q < LEVEL_WIDTH'(MAX_LEVEL)) ? level_q + LEVEL_WIDTH'(1) : level_q;
   end
   always_ff @(posedge CLOCK_50 or posedge RESET_InHigh) begin
      if (RESET_InHigh) level_q <= '0;
      else              level_q <= level_d;
   end
   assign level_OutBUS = level_q;
   for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_lane
      cc_speedtick_lane #(
         .DATAWIDTH   (DATAWIDTH),
         .LEVEL_WIDTH (LEVEL_WIDTH)
      ) u_lane (
         .clk    (CLOCK_50),
         .rst    (RESET_InHigh),
         .period (period_InBUS[c*DATAWIDTH +: DATAWIDTH]),
         .level  (level_q),
         .run    (run),
         .tick_n (tick_OutLow[c])
      );
   end
endmodule

// File: tb/tb_cc_speedtick_gen.sv
// tb_cc_speedtick_gen: scoreboard bench; a per-edge reference model queues the
// expected outputs and a negedge monitor compares them against the DUT.
module tb_cc_speedtick_gen;
   localparam int DW = 23;
   localparam int NC = 4;
   localparam int LW = 3;
   localparam int ML = 5;

   typedef struct {
      logic [NC-1:0] t;
      logic [LW-1:0] l;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [NC*DW-1:0] per = '0;
   logic             up = 1'b0, clr = 1'b0, pause_n = 1'b1;
   logic [NC-1:0]    tick_n;
   logic [LW-1:0]    lvl;

   int   total = 0, bad = 0;
   int   m_cnt[NC];
   int   m_lvl = 0;
   exp_t q[$];

   always #5 clk = ~clk;

   cc_speedtick_gen #(.DATAWIDTH(DW), .NUM_CHANNELS(NC), .LEVEL_WIDTH(LW), .MAX_LEVEL(ML)) dut (
      .CLOCK_50       (clk),
      .RESET_InHigh   (rst),
      .period_InBUS   (per),
      .level_up_In    (up),
      .level_clear_In (clr),
`ifdef CC_SPEEDTICK_PAUSE_EN
      .pause_InLow    (pause_n),
`endif
      .tick_OutLow    (tick_n),
      .level_OutBUS   (lvl)
   );

   function automatic int eff_m(input int p, input int l);
      int e;
      e = p >> l;
      return (p != 0 && e == 0) ? 1 : e;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < NC; c++) m_cnt[c] = 0;
      m_lvl = 0;
   endtask

   // Reference: each channel wraps when its count reaches eff-1 of the level
   // seen at this edge; the level update takes effect for the next edge.
   task automatic model_step();
      exp_t e;
      if (rst) begin
         model_reset();
         e.t = '1;
         e.l = '0;
      end else begin
         for (int c = 0; c < NC; c++) begin
            int p, ef;
            p  = int'(per[c*DW +: DW]);
            ef = eff_m(p, m_lvl);
            if (ef == 0) begin
               m_cnt[c] = 0;
               e.t[c] = 1'b1;
            end else if (!pause_n) begin
               e.t[c] = 1'b1;
            end else if (m_cnt[c] >= ef - 1) begin
               m_cnt[c] = 0;
               e.t[c] = 1'b0;
            end else begin
               m_cnt[c]++;
               e.t[c] = 1'b1;
            end
         end
         if (clr) m_lvl = 0;
         else if (up && m_lvl < ML) m_lvl++;
         e.l = LW'(m_lvl);
      end
      q.push_back(e);
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   initial forever begin
      exp_t e;
      @(negedge clk);
      if (q.size() > 0) begin
         e = q.pop_front();
         chk("tick", 32'(tick_n), 32'(e.t));
         chk("level", 32'(lvl), 32'(e.l));
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse(input logic u, input logic c);
      @(negedge clk);
      up = u;
      clr = c;
      @(negedge clk);
      up = 1'b0;
      clr = 1'b0;
   endtask

   task automatic set_per(input int ch, input int p);
      per[ch*DW +: DW] = DW'(p);
   endtask

   // Reset lands between edges; outputs must change without a clock edge.
   task automatic async_reset(input int hold);
      @(posedge clk);
      #3;
      rst = 1'b1;
      q.delete();
      model_reset();
      #1;
      chk("async_rst_tick", 32'(tick_n), 32'({NC{1'b1}}));
      chk("async_rst_level", 32'(lvl), 32'd0);
      repeat (hold) @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      set_per(0, 5);
      cyc(3);
      chk("reset_tick", 32'(tick_n), 32'({NC{1'b1}}));
      chk("reset_level", 32'(lvl), 32'd0);
      rst = 1'b0;
      cyc(16);
      set_per(0, 8);
      pulse(1'b1, 1'b0);
      pulse(1'b1, 1'b0);
      cyc(10);
      pulse(1'b0, 1'b1);
      cyc(20);
      async_reset(2);
      set_per(0, 100);
      cyc(61);
      set_per(0, 20);
      cyc(45);
      set_per(0, 3);
      repeat (10) pulse(1'b1, 1'b0);
      cyc(5);
      pulse(1'b1, 1'b1);
      cyc(4);
      set_per(0, 7);
      set_per(3, 1);
      pulse(1'b1, 1'b0);
      cyc(4);
      async_reset(2);
      cyc(20);
`ifdef CC_SPEEDTICK_PAUSE_EN
      async_reset(1);
      set_per(0, 4);
      set_per(3, 0);
      cyc(2);
      pause_n = 1'b0;
      pulse(1'b1, 1'b0);
      cyc(5);
      pause_n = 1'b1;
      cyc(10);
`endif
      for (int c = 0; c < NC; c++) set_per(c, $urandom_range(0, 12));
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         up  = $urandom_range(0, 9) == 0;
         clr = $urandom_range(0, 39) == 0;
`ifdef CC_SPEEDTICK_PAUSE_EN
         pause_n = $urandom_range(0, 7) != 0;
`endif
         if ($urandom_range(0, 19) == 0) set_per($urandom_range(0, NC - 1), $urandom_range(0, 12));
         if ($urandom_range(0, 149) == 0) begin
            up = 1'b0;
            clr = 1'b0;
            async_reset(1);
         end
      end
      up = 1'b0;
      clr = 1'b0;
      pause_n = 1'b1;
      cyc(3);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
